flag_sequencer: RTL and testbench
=================================

Name: flag_sequencer

Overview:
Frame-synchronous controller that drives the 7-bit flag selector of the flag lookup datapath.
- Steps forward/backward on user buttons, with hold-to-repeat.
- Optionally auto-cycles (slideshow) after a programmable dwell.
- Wraps at the datapath-reported maximum index.
- Sits between the TT input pins and the flag lookup; updates only on frame boundaries so no frame shows two flags.

Parameters:
SEL_W, 7, selector/max width
DWELL_FRAMES, 180, frames per flag in auto mode (3 s at 60 Hz); legal range 1..65535
REPEAT_DELAY, 30, frames a button must be held before the first repeat step
REPEAT_RATE, 6, frames between repeat steps once repeating
CNT_W, 16, frame counter width; must satisfy 2^CNT_W > max(DWELL_FRAMES, REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse per frame, start of vertical blank, from VGA timing
btn_next  in  1  asynchronous level, high = pressed
btn_prev  in  1  asynchronous level, high = pressed
auto_en  in  1  asynchronous level, high = slideshow enabled
max  in  SEL_W  highest valid selector, combinational from the flag lookup
selector  out  SEL_W  registered flag index
changed  out  1  one-cycle pulse, coincident with any selector update
auto_active  out  1  registered; high while slideshow is counting

Behaviour:
- Reset (rst_n low, async): selector=0, changed=0, auto_active=0, all counters 0, FSM=IDLE, synchronizers and previous-sample registers 0.
- Input synchronization:
  - btn_next, btn_prev and auto_en each pass through a 2-FF synchronizer.
  - Synchronized levels are sampled only on frame_start cycles. Once-per-frame sampling is the debounce.
  - prev_sample registers hold the previous frame's samples.
- All state updates happen only in the cycle frame_start=1. selector and changed take effect on the next clk edge, so latency is 1 clk after frame_start. changed is otherwise 0.
- Step rules, with max sampled in the same cycle:
  - next: selector = (selector >= max) ? 0 : selector+1
  - prev: selector = (selector == 0 || selector > max) ? max : selector-1
  - Both buttons sampled high on the same frame (either newly or held): selector=0, FSM=IDLE, no repeat.
  - selector > max with no step requested: clamp selector to 0 and pulse changed.
- Button FSM. "Press" = sampled high this frame and low last frame; only one button high.
  - IDLE:
    - On press: step once, hold_cnt=0, go to DELAY.
  - DELAY:
    - Same button still high: hold_cnt++. When hold_cnt reaches REPEAT_DELAY-1: step, hold_cnt=0, go to REPEAT.
    - Button released: go to IDLE.
    - Other button pressed alone: treat as a fresh press (step, hold_cnt=0, stay in DELAY, track the new button).
  - REPEAT:
    - Button still high: hold_cnt++. When hold_cnt reaches REPEAT_RATE-1: step, hold_cnt=0.
    - Release and other-button handling are the same as in DELAY.
- Auto mode:
  - auto_active = synced auto_en AND FSM==IDLE AND neither button sampled high.
  - While auto_active: dwell_cnt++ per frame. When dwell_cnt reaches DWELL_FRAMES-1: step next, dwell_cnt=0.
  - Any button step, or auto_active low, clears dwell_cnt.
- Counter rules: counters saturate and never wrap. The FSM is one-hot or binary (implementer's choice); unreachable encodings return to IDLE.
- Outside frame_start cycles, buttons and max are ignored, so mid-frame glitches are invisible.
- max=0: next and prev both hold selector at 0. changed still pulses on the step.

Decomposition:
- Shared package flag_pkg:
  - SEL_W
  - FSM state enum: IDLE, DELAY, REPEAT
  - default timing constants
- Sub-module sync_2ff: 1-bit two-flop synchronizer, instantiated three times.
- Step arithmetic is a function in flag_pkg: wrap_step(sel, max, dir).

Test Plan:
1. Reset, then tap btn_next for 1 frame with max=81 -> selector 0->1 one clk after frame_start; changed high exactly 1 cycle.
2. Tap btn_prev with selector=0, max=81 -> selector=81. Tap btn_next at selector=81 -> selector=0.
3. Hold btn_next 60 frames from selector=0, REPEAT_DELAY=30, REPEAT_RATE=6:
   - steps at frames 0, 30, 36, 42, 48, 54 -> selector=6.
   - Release -> no further steps; FSM returns to IDLE.
4. auto_en=1, no buttons, DWELL_FRAMES=4 -> selector increments every 4th frame.
   - Press btn_prev mid-dwell -> immediate decrement and dwell restart.
   - Assert both buttons -> selector=0.
5. selector=50, then max driven to 20 -> selector=0 on next frame_start with changed pulse.
   - Pulse rst_n low mid-frame -> all outputs 0 immediately, asynchronously.
6. Toggle btn_next several times between frame_start pulses while sampled level stays low -> no selector change.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared types, default timing and step arithmetic
// for the flag selector sequencer.
package flag_pkg;

   localparam int unsigned SEL_W            = 7;
   localparam int unsigned DEF_CNT_W        = 16;
   localparam int unsigned DEF_DWELL_FRAMES = 180;
   localparam int unsigned DEF_REPEAT_DELAY = 30;
   localparam int unsigned DEF_REPEAT_RATE  = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_e;

   typedef enum logic {
      DIR_NEXT = 1'b0,
      DIR_PREV = 1'b1
   } dir_e;

   // One step with wrap; out-of-range selectors land on 0 / max
   function automatic logic [SEL_W-1:0] wrap_step(
      input logic [SEL_W-1:0] sel,
      input logic [SEL_W-1:0] mx,
      input dir_e             dir
   );
      logic [SEL_W-1:0] r;
      if (dir == DIR_NEXT) begin
         r = (sel >= mx) ? '0 : sel + 1'b1;
      end else begin
         r = (sel == '0 || sel > mx) ? mx : sel - 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level.
// Reset clears both stages.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Shift the level through two flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/flag_sequencer.sv
// Frame-synchronous flag selector: button step/repeat,
// slideshow dwell, wrap at max; updates on frame_start only.
module flag_sequencer
   import flag_pkg::*;
#(
   parameter int unsigned DWELL_FRAMES = DEF_DWELL_FRAMES,
   parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             btn_next,
   input  logic             btn_prev,
   input  logic             auto_en,
   input  logic [SEL_W-1:0] max,
   output logic [SEL_W-1:0] selector,
   output logic             changed,
   output logic             auto_active
);

   localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LIM = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] DW_LIM = CNT_W'(DWELL_FRAMES - 1);

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic n_s, p_s, a_s;

   sync_2ff u_sync_next (
      .clk(clk), .rst_n(rst_n), .d_i(btn_next), .q_o(n_s)
   );
   sync_2ff u_sync_prev (
      .clk(clk), .rst_n(rst_n), .d_i(btn_prev), .q_o(p_s)
   );
   sync_2ff u_sync_auto (
      .clk(clk), .rst_n(rst_n), .d_i(auto_en), .q_o(a_s)
   );

   state_e           st_q, st_d;
   dir_e             dir_q, dir_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             chg_q, chg_d;
   logic             act_q, act_d;
   logic             pn_q, pn_d;
   logic             pp_q, pp_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;

   logic             step;
   dir_e             sdir;
   logic             press_n, press_p;
   logic             held, act;
   logic [CNT_W-1:0] lim;

   // Next-state: everything moves only on a frame_start cycle
   always_comb begin
      st_d    = st_q;
      dir_d   = dir_q;
      sel_d   = sel_q;
      chg_d   = 1'b0;
      act_d   = act_q;
      pn_d    = pn_q;
      pp_d    = pp_q;
      hold_d  = hold_q;
      dwell_d = dwell_q;
      step    = 1'b0;
      sdir    = DIR_NEXT;
      press_n = n_s & ~pn_q & ~p_s;
      press_p = p_s & ~pp_q & ~n_s;
      held    = (dir_q == DIR_NEXT) ? n_s : p_s;
      act     = a_s & (st_q == IDLE) & ~n_s & ~p_s;
      lim     = (st_q == DELAY) ? RD_LIM : RR_LIM;
      if (frame_start) begin
         pn_d  = n_s;
         pp_d  = p_s;
         act_d = act;
         if (n_s & p_s) begin
            st_d    = IDLE;
            hold_d  = '0;
            dwell_d = '0;
            sel_d   = '0;
            chg_d   = (sel_q != '0);
         end else begin
            unique case (st_q)
               IDLE: begin
                  if (press_n | press_p) begin
                     step   = 1'b1;
                     sdir   = press_p ? DIR_PREV : DIR_NEXT;
                     dir_d  = sdir;
                     hold_d = '0;
                     st_d   = DELAY;
                  end
               end
               DELAY, REPEAT: begin
                  if (press_n | press_p) begin
                     step   = 1'b1;
                     sdir   = press_p ? DIR_PREV : DIR_NEXT;
                     dir_d  = sdir;
                     hold_d = '0;
                     st_d   = DELAY;
                  end else if (held) begin
                     if (hold_q >= lim) begin
                        step   = 1'b1;
                        sdir   = dir_q;
                        hold_d = '0;
                        st_d   = REPEAT;
                     end else begin
                        hold_d = sat_inc(hold_q);
                     end
                  end else begin
                     hold_d = '0;
                     st_d   = IDLE;
                  end
               end
               default: begin
                  hold_d = '0;
                  st_d   = IDLE;
               end
            endcase
            if (act && dwell_q >= DW_LIM) begin
               step    = 1'b1;
               sdir    = DIR_NEXT;
               dwell_d = '0;
            end else if (act) begin
               dwell_d = sat_inc(dwell_q);
            end else begin
               dwell_d = '0;
            end
            if (step) begin
               sel_d = wrap_step(sel_q, max, sdir);
               chg_d = 1'b1;
            end else if (sel_q > max) begin
               sel_d = '0;
               chg_d = 1'b1;
            end
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= IDLE;
         dir_q   <= DIR_NEXT;
         sel_q   <= '0;
         chg_q   <= 1'b0;
         act_q   <= 1'b0;
         pn_q    <= 1'b0;
         pp_q    <= 1'b0;
         hold_q  <= '0;
         dwell_q <= '0;
      end else begin
         st_q    <= st_d;
         dir_q   <= dir_d;
         sel_q   <= sel_d;
         chg_q   <= chg_d;
         act_q   <= act_d;
         pn_q    <= pn_d;
         pp_q    <= pp_d;
         hold_q  <= hold_d;
         dwell_q <= dwell_d;
      end
   end

   assign selector    = sel_q;
   assign changed     = chg_q;
   assign auto_active = act_q;

endmodule

// File: tb/tb_flag_sequencer.sv
// Bench for flag_sequencer: vector table, directed
// corner sequences and random frames against a model.
module tb_flag_sequencer;

   localparam int RD = 30;
   localparam int RR = 6;
   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic       auto_en = 1'b0;
   logic [6:0] max_r = 7'd81;
   logic [6:0] selector;
   logic       changed;
   logic       auto_active;

   always #5 clk = ~clk;

   flag_sequencer #(
      .DWELL_FRAMES(DW),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .frame_start(frame_start),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .auto_en(auto_en),
      .max(max_r),
      .selector(selector),
      .changed(changed),
      .auto_active(auto_active)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;

   // Behavioural reference: frames held / active-frame runs
   int m_sel, m_trk, m_held, m_run;
   bit m_chg, m_act, m_pn, m_pp;

   task automatic model_reset();
      m_sel = 0; m_trk = 0; m_held = 0; m_run = 0;
      m_chg = 0; m_act = 0; m_pn = 0; m_pp = 0;
   endtask

   task automatic model_frame(input bit n, input bit p,
                              input bit a, input int mx);
      bit pn_new, pp_new, act;
      int sd;
      pn_new = n && !m_pn && !p;
      pp_new = p && !m_pp && !n;
      act = a && (m_trk == 0) && !n && !p;
      sd = 0;
      m_chg = 0;
      if (n && p) begin
         m_chg = (m_sel != 0);
         m_sel = 0;
         m_trk = 0;
         m_run = 0;
      end else begin
         if (pn_new || pp_new) begin
            m_trk = pn_new ? 1 : 2;
            m_held = 0;
            sd = pn_new ? 1 : -1;
         end else if (m_trk != 0) begin
            if ((m_trk == 1 && n) || (m_trk == 2 && p)) begin
               m_held++;
               if (m_held == RD ||
                   (m_held > RD && (m_held - RD) % RR == 0))
                  sd = (m_trk == 1) ? 1 : -1;
            end else begin
               m_trk = 0;
            end
         end
         if (act) begin
            m_run++;
            if (m_run % DW == 0) sd = 1;
         end else begin
            m_run = 0;
         end
         if (sd == 1) begin
            m_sel = (m_sel >= mx) ? 0 : m_sel + 1;
            m_chg = 1;
         end else if (sd == -1) begin
            m_sel = (m_sel == 0 || m_sel > mx) ? mx : m_sel - 1;
            m_chg = 1;
         end else if (m_sel > mx) begin
            m_sel = 0;
            m_chg = 1;
         end
      end
      m_act = act;
      m_pn = n;
      m_pp = p;
   endtask

   task automatic check(input string name, input int got,
                        input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d @%0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic check_model();
      check("sel", int'(selector), m_sel);
      check("chg", int'(changed), int'(m_chg));
      check("act", int'(auto_active), int'(m_act));
   endtask

   task automatic launch(input int mx);
      max_r = 7'(mx);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic finish_frame(input bit n, input bit p,
                               input bit a, input int mx);
      model_frame(n, p, a, mx);
      check_model();
      if (changed) pulses++;
      @(negedge clk);
      check("chg_1cyc", int'(changed), 0);
   endtask

   task automatic frame(input bit n, input bit p,
                        input bit a, input int mx);
      @(negedge clk);
      btn_next = n; btn_prev = p; auto_en = a;
      repeat (3) @(negedge clk);
      launch(mx);
      finish_frame(n, p, a, mx);
   endtask

   // Button chatter and max dips between samples are ignored
   task automatic glitch_frame();
      @(negedge clk);
      btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         btn_next = ~btn_next;
         max_r = (i % 2 == 0) ? 7'd0 : 7'd81;
         @(negedge clk);
      end
      btn_next = 1'b0;
      max_r = 7'd0;
      repeat (3) @(negedge clk);
      launch(81);
      finish_frame(0, 0, 0, 81);
   endtask

   typedef struct packed {
      bit       n;
      bit       p;
      bit       a;
      logic [6:0] mx;
      logic [6:0] sel;
      bit       chg;
      bit       act;
   } vec_t;

   function automatic vec_t mkv(input bit n, input bit p,
                                input bit a, input int mx,
                                input int sel, input bit chg,
                                input bit act);
      vec_t v;
      v.n = n; v.p = p; v.a = a;
      v.mx = 7'(mx); v.sel = 7'(sel);
      v.chg = chg; v.act = act;
      return v;
   endfunction

   vec_t vecs[17];
   bit   rn, rp, ra;
   int   rmx;

   initial begin
      vecs[0]  = mkv(1, 0, 0, 81,  1, 1, 0);
      vecs[1]  = mkv(0, 0, 0, 81,  1, 0, 0);
      vecs[2]  = mkv(0, 1, 0, 81,  0, 1, 0);
      vecs[3]  = mkv(0, 0, 0, 81,  0, 0, 0);
      vecs[4]  = mkv(0, 1, 0, 81, 81, 1, 0);
      vecs[5]  = mkv(0, 0, 0, 81, 81, 0, 0);
      vecs[6]  = mkv(1, 0, 0, 81,  0, 1, 0);
      vecs[7]  = mkv(0, 0, 0, 81,  0, 0, 0);
      vecs[8]  = mkv(1, 0, 0,  0,  0, 1, 0);
      vecs[9]  = mkv(0, 0, 0,  0,  0, 0, 0);
      vecs[10] = mkv(0, 1, 0,  0,  0, 1, 0);
      vecs[11] = mkv(0, 0, 0,  0,  0, 0, 0);
      vecs[12] = mkv(0, 0, 1, 81,  0, 0, 1);
      vecs[13] = mkv(0, 0, 1, 81,  0, 0, 1);
      vecs[14] = mkv(0, 0, 1, 81,  0, 0, 1);
      vecs[15] = mkv(0, 0, 1, 81,  1, 1, 1);
      vecs[16] = mkv(0, 0, 0, 81,  1, 0, 0);

      model_reset();
      repeat (3) @(negedge clk);
      check("rst_sel", int'(selector), 0);
      check("rst_chg", int'(changed), 0);
      check("rst_act", int'(auto_active), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         frame(vecs[i].n, vecs[i].p, vecs[i].a, int'(vecs[i].mx));
         check($sformatf("vec%0d_sel", i),
               int'(selector), int'(vecs[i].sel));
         check($sformatf("vec%0d_act", i),
               int'(auto_active), int'(vecs[i].act));
      end

      // Both buttons force 0, then hold-to-repeat from 0
      frame(1, 1, 0, 81);
      check("both_sel", int'(selector), 0);
      frame(0, 0, 0, 81);
      pulses = 0;
      for (int f = 0; f < 60; f++) frame(1, 0, 0, 81);
      check("hold_steps", pulses, 6);
      check("hold_sel", int'(selector), 6);
      for (int f = 0; f < 10; f++) frame(0, 0, 0, 81);
      check("release_steps", pulses, 6);
      check("release_sel", int'(selector), 6);

      // Slideshow, prev mid-dwell, then both buttons
      for (int f = 0; f < 4; f++) frame(0, 0, 1, 81);
      check("dwell_sel", int'(selector), 7);
      frame(0, 0, 1, 81);
      frame(0, 0, 1, 81);
      frame(0, 1, 1, 81);
      check("prev_mid_dwell", int'(selector), 6);
      frame(0, 0, 1, 81);
      for (int f = 0; f < 3; f++) frame(0, 0, 1, 81);
      check("dwell_restart", int'(selector), 6);
      frame(0, 0, 1, 81);
      check("dwell_again", int'(selector), 7);
      frame(1, 1, 1, 81);
      check("both_auto", int'(selector), 0);
      frame(0, 0, 0, 81);

      // Clamp when max drops under selector
      frame(0, 1, 0, 50);
      check("prev_to_50", int'(selector), 50);
      frame(0, 0, 0, 50);
      frame(0, 0, 0, 20);
      check("clamp_sel", int'(selector), 0);
      check("clamp_chg", int'(m_chg), 1);

      // Asynchronous reset mid-frame
      frame(1, 0, 0, 81);
      frame(0, 0, 1, 81);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_sel", int'(selector), 0);
      check("arst_chg", int'(changed), 0);
      check("arst_act", int'(auto_active), 0);
      auto_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Mid-frame chatter is invisible
      frame(1, 0, 0, 81);
      frame(0, 0, 0, 81);
      glitch_frame();
      check("glitch_sel", int'(selector), 1);
      glitch_frame();

      // Random frames against the model
      rn = 0; rp = 0; ra = 0; rmx = 81;
      for (int f = 0; f < 400; f++) begin
         if ($urandom_range(0, 9) < 2) rn = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 9) < 2) rp = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 19) == 0) ra = ~ra;
         if ($urandom_range(0, 29) == 0) rmx = $urandom_range(0, 127);
         frame(rn, rp, ra, rmx);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
